dac_spi_scheduler: RTL and testbench
====================================

// Module: dac_spi_scheduler
// PURPOSE
//  Round-robin scheduler sharing one DAC serial-write engine among NREQ requesters.
//  Latches the winner's command/address/data and drives them to the engine.
//  Sequences the engine's start level, watches its frame strobe, and acknowledges
//  the requester. Sits between slow-control/calibration masters and the DAC serial engine.
// PARAMETERS
//  NREQ        4     number of requesters (2..8)
//  GAP_CYC     8     idle cycles, start held low, between frames (>=2)
//  TIMEOUT_CYC 4096  max cycles from start-high to end of frame; exceeding this aborts
// PORTS
//  clk          in   1         system clock, all logic on rising edge
//  rst          in   1         asynchronous, active-low reset
//  req          in   NREQ      per-requester write request; level, held until done
//  req_comm     in   4*NREQ    requester i command nibble at [4i+3:4i]
//  req_addr     in   4*NREQ    requester i DAC channel address at [4i+3:4i]
//  req_data     in   16*NREQ   requester i DAC code at [16i+15:16i]
//  gnt          out  NREQ      one-hot; high from LOAD through GAP for the serviced requester
//  done         out  NREQ      one-cycle pulse to the serviced requester at frame end
//  timeout_err  out  1         one-cycle pulse with done when the frame timed out
//  busy         out  1         high in any state other than IDLE
//  dac_comm     out  4         to engine command input; registered, stable for the whole frame
//  dac_addr     out  4         to engine address input; registered
//  dac_data     out  16        to engine data input; registered
//  dac_ext_ctrl out  1         to engine start input; level, active high
//  dac_sync     in   1         engine frame strobe, active low during shifting
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr_ptr=NREQ-1, so requester 0 has first priority.
//  Reset mid-frame: dac_ext_ctrl drops at once, which aborts the engine. No done is issued.
//  FSM states:
//   IDLE : if |req, go to ARB next cycle.
//   ARB  : pick the first set req scanning rr_ptr+1, rr_ptr+2, ... (mod NREQ).
//          Set rr_ptr=winner. Register the winner's comm/addr/data onto the dac_* outputs.
//          Set gnt. Go to LOAD. If req cleared meanwhile, go back to IDLE with no grant.
//   LOAD : dac_ext_ctrl=0 for exactly 1 cycle so the engine captures stable operands.
//          Go to RUN.
//   RUN  : dac_ext_ctrl=1; timer counts. When dac_sync is sampled 0, go to XFER.
//   XFER : dac_ext_ctrl=1. When dac_sync is sampled 1 (rising edge of strobe):
//          drop dac_ext_ctrl the next cycle, pulse done[winner], go to GAP.
//   GAP  : dac_ext_ctrl=0 for GAP_CYC cycles. Then clear gnt and go to IDLE.
//          In IDLE, re-arbitration happens the following cycle.
//  Timer: clears on entry to RUN and saturates. If it reaches TIMEOUT_CYC in RUN or XFER:
//   dac_ext_ctrl=0, done[winner]=1, timeout_err=1 (same cycle), go to GAP.
//  Engine restart window: the engine may re-arm for one cycle before dac_ext_ctrl falls.
//   That produces no strobe and is tolerated.
//   The engine gap between start-low and the next start-high is >= GAP_CYC+1 cycles.
//  Operand stability: dac_comm/addr/data change only in ARB and are held through GAP.
//   Requester inputs changing after ARB have no effect on the frame in progress.
//  Requester drops req after grant: the frame still completes and done still pulses.
//  Simultaneous requests: strict round-robin. No requester is served twice
//   while another has req held.
//  Latency: req rising in IDLE -> dac_ext_ctrl high = 3 cycles (IDLE, ARB, LOAD).
//  done stays low outside the frame-end cycle. At most one done bit is set at any time.
// TESTING
//  1 Single req[0], comm=3 addr=5 data=16'hA5C3: engine model strobes 0011_0101_A5C3;
//    done[0] pulses once; gnt[0] clears after GAP_CYC.
//  2 req=4'b1111 held: service order 0,1,2,3,0; each done is a single pulse;
//    GAP_CYC low cycles on dac_ext_ctrl between frames.
//  3 After req2 is served, req=4'b0101: requester 0 is served next, then 2.
//  4 dac_sync tied high: after TIMEOUT_CYC cycles dac_ext_ctrl falls;
//    done[w] and timeout_err pulse together; next request is still serviced.
//  5 rst asserted during XFER: all outputs 0 asynchronously;
//    after release, req[0] is the first to be granted.
//  6 req_data changed mid-frame: shifted word equals the value latched in ARB.

Source files
------------

// File: rtl/dac_spi_scheduler_if.sv
// Requester-side and engine-side signal bundle for the DAC serial-write scheduler.
interface dac_spi_scheduler_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [4*NREQ-1:0]  req_comm;
    logic [4*NREQ-1:0]  req_addr;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               timeout_err;
    logic               busy;
    logic [3:0]         dac_comm;
    logic [3:0]         dac_addr;
    logic [15:0]        dac_data;
    logic               dac_ext_ctrl;
    logic               dac_sync;

    modport slave (
        input  req, req_comm, req_addr, req_data, dac_sync,
        output gnt, done, timeout_err, busy, dac_comm, dac_addr, dac_data, dac_ext_ctrl
    );

    modport master (
        output req, req_comm, req_addr, req_data, dac_sync,
        input  gnt, done, timeout_err, busy, dac_comm, dac_addr, dac_data, dac_ext_ctrl
    );
endinterface

// File: rtl/dac_spi_scheduler.sv
// Round-robin scheduler sharing one DAC serial-write engine among NREQ requesters.
// Latches the winner's operands, sequences the engine start level and acks on frame end.
module dac_spi_scheduler #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned GAP_CYC     = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input logic                clk,
    input logic                rst,
    dac_spi_scheduler_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GW = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StLoad,
        StRun,
        StXfer,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            timeout_err_q, timeout_err_d;
    logic [3:0]      comm_q, comm_d;
    logic [3:0]      addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic            ext_q, ext_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   scan_idx;
    logic            win_found;
    logic            timer_hit;

    // Scan rr_ptr+1, rr_ptr+2, ... so the last winner has the lowest priority.
    always_comb begin
        win_idx   = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        win_found = 1'b0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            scan_idx = IW'((int'(rr_ptr_q) + i) % int'(NREQ));
            if (!win_found && bus.req[scan_idx]) begin
                win_idx   = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    // timer_q holds the number of completed start-high cycles in the current frame.
    assign timer_hit = (timer_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        done_d        = '0;
        timeout_err_d = 1'b0;
        comm_d        = comm_q;
        addr_d        = addr_q;
        data_d        = data_q;
        ext_d         = 1'b0;
        timer_d       = timer_q;
        gap_d         = gap_q;

        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (win_found) begin
                    rr_ptr_d         = win_idx;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    comm_d           = bus.req_comm[4*win_idx +: 4];
                    addr_d           = bus.req_addr[4*win_idx +: 4];
                    data_d           = bus.req_data[16*win_idx +: 16];
                    state_d          = StLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StLoad: begin
                timer_d = '0;
                ext_d   = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                if (timer_hit) begin
                    done_d        = gnt_q;
                    timeout_err_d = 1'b1;
                    gap_d         = '0;
                    state_d       = StGap;
                end else begin
                    ext_d   = 1'b1;
                    timer_d = timer_q + 1'b1;
                    if (!bus.dac_sync) begin
                        state_d = StXfer;
                    end
                end
            end
            StXfer: begin
                // A completed strobe wins over a timeout landing in the same cycle.
                if (bus.dac_sync) begin
                    done_d  = gnt_q;
                    gap_d   = '0;
                    state_d = StGap;
                end else if (timer_hit) begin
                    done_d        = gnt_q;
                    timeout_err_d = 1'b1;
                    gap_d         = '0;
                    state_d       = StGap;
                end else begin
                    ext_d   = 1'b1;
                    timer_d = timer_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    gnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            rr_ptr_q      <= IW'(NREQ - 1);
            gnt_q         <= '0;
            done_q        <= '0;
            timeout_err_q <= 1'b0;
            comm_q        <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            ext_q         <= 1'b0;
            timer_q       <= '0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            comm_q        <= comm_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            ext_q         <= ext_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.dac_comm     = comm_q;
    assign bus.dac_addr     = addr_q;
    assign bus.dac_data     = data_q;
    assign bus.dac_ext_ctrl = ext_q;
endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Bench for dac_spi_scheduler: serial-engine model plus a round-robin reference model.
module tb_dac_spi_scheduler;
    localparam int NREQ        = 4;
    localparam int GAP_CYC     = 8;
    localparam int TIMEOUT_CYC = 4096;
    localparam int SHIFT_LEN   = 24;

    logic clk;
    logic rst;
    int   vecs;
    int   errs;
    int   rr_last;
    bit   eng_en;
    logic [23:0] op_word [NREQ];
    logic [23:0] eng_words [$];

    dac_spi_scheduler_if #(.NREQ(NREQ)) bus ();

    dac_spi_scheduler #(
        .NREQ        (NREQ),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine: latches operands when start rises, strobes sync low for SHIFT_LEN cycles.
    initial begin : engine
        int          ph;
        int          cnt;
        logic [23:0] w;
        ph = 0;
        cnt = 0;
        w = '0;
        bus.dac_sync = 1'b1;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 || ((ph == 1 || ph == 2) && bus.dac_ext_ctrl !== 1'b1)) begin
                bus.dac_sync = 1'b1;
                ph = 0;
            end else begin
                case (ph)
                    0: if (eng_en && bus.dac_ext_ctrl === 1'b1) begin
                        w   = {bus.dac_comm, bus.dac_addr, bus.dac_data};
                        cnt = $urandom_range(1, 5);
                        ph  = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.dac_sync = 1'b0;
                            cnt = SHIFT_LEN;
                            ph  = 2;
                        end
                    end
                    2: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.dac_sync = 1'b1;
                            eng_words.push_back(w);
                            ph = 3;
                        end
                    end
                    default: if (bus.dac_ext_ctrl !== 1'b1) ph = 0;
                endcase
            end
        end
    end

    function automatic int model_pick(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(rr_last + k) % NREQ]) return (rr_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_ops(input int i, input logic [3:0] c, input logic [3:0] a,
                           input logic [15:0] d);
        bus.req_comm[4*i +: 4]   = c;
        bus.req_addr[4*i +: 4]   = a;
        bus.req_data[16*i +: 16] = d;
        op_word[i] = {c, a, d};
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, 4'($urandom), 4'($urandom), 16'($urandom));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rr_last = NREQ - 1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, bus.busy, n);
        end
    endtask

    // Waits for done, checks winner, flags and shifted word; returns one cycle after done.
    task automatic expect_frame(input int exp_w, input string name);
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] got;
        logic [23:0]     word;
        bit              seen;
        oh = '0;
        oh[exp_w] = 1'b1;
        seen = 1'b0;
        got = '0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (bus.done !== '0) begin
                seen = 1'b1;
                got  = bus.done;
            end
        end
        vecs++;
        if (!seen) begin
            errs++;
            $display("FAIL %s: no done within bound, required done=%b", name, oh);
            return;
        end
        vecs++;
        if (got !== oh || bus.gnt !== oh) begin
            errs++;
            $display("FAIL %s winner: done=%b gnt=%b, required %b", name, got, bus.gnt, oh);
        end
        vecs++;
        if (bus.timeout_err !== 1'b0 || bus.dac_ext_ctrl !== 1'b0) begin
            errs++;
            $display("FAIL %s flags: timeout_err=%b ext=%b, required 0 0",
                     name, bus.timeout_err, bus.dac_ext_ctrl);
        end
        word = (eng_words.size() > 0) ? eng_words.pop_front() : 24'hxxxxxx;
        vecs++;
        if (word !== op_word[exp_w]) begin
            errs++;
            $display("FAIL %s word: shifted=%h, required %h", name, word, op_word[exp_w]);
        end
        rr_last = exp_w;
        @(negedge clk);
        vecs++;
        if (bus.done !== '0) begin
            errs++;
            $display("FAIL %s pulse: done=%b one cycle later, required 0", name, bus.done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = '0;
        rand_ops();
        repeat (2) @(negedge clk);
        vecs++;
        if (bus.gnt !== '0 || bus.done !== '0 || bus.timeout_err !== 1'b0
            || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctrl: gnt=%b done=%b to=%b busy=%b, required all 0",
                     bus.gnt, bus.done, bus.timeout_err, bus.busy);
        end
        vecs++;
        if ({bus.dac_comm, bus.dac_addr, bus.dac_data, bus.dac_ext_ctrl} !== 25'd0) begin
            errs++;
            $display("FAIL reset_dac: comm=%h addr=%h data=%h ext=%b, required all 0",
                     bus.dac_comm, bus.dac_addr, bus.dac_data, bus.dac_ext_ctrl);
        end
        rst = 1'b1;
        rr_last = NREQ - 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cnt;
        set_ops(0, 4'h3, 4'h5, 16'hA5C3);
        bus.req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        vecs++;
        if (bus.dac_ext_ctrl !== 1'b0 || bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL single_load: ext=%b gnt=%b busy=%b, required 0 0001 1",
                     bus.dac_ext_ctrl, bus.gnt, bus.busy);
        end
        @(negedge clk);
        vecs++;
        if (bus.dac_ext_ctrl !== 1'b1) begin
            errs++;
            $display("FAIL single_latency: ext=%b at 3 cycles, required 1", bus.dac_ext_ctrl);
        end
        vecs++;
        if (op_word[0] !== 24'h35A5C3) begin
            errs++;
            $display("FAIL single_opword: %h, required 35a5c3", op_word[0]);
        end
        expect_frame(0, "single");
        bus.req = '0;
        cnt = 1;
        while (bus.gnt !== '0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        vecs++;
        if (cnt !== GAP_CYC) begin
            errs++;
            $display("FAIL single_gap: gnt held %0d cycles, required %0d", cnt, GAP_CYC);
        end
        wait_idle("single_idle");
    endtask

    task automatic test_all_held();
        int cnt;
        do_reset();
        rand_ops();
        bus.req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            expect_frame(model_pick(bus.req), "all_held");
            if (f < 4) begin
                cnt = 1;
                while (bus.dac_ext_ctrl === 1'b0 && cnt < 1000) begin
                    cnt++;
                    @(negedge clk);
                end
                vecs++;
                if (cnt !== GAP_CYC + 3) begin
                    errs++;
                    $display("FAIL all_held_gap: start low %0d cycles, required %0d",
                             cnt, GAP_CYC + 3);
                end
            end
        end
        bus.req = '0;
        wait_idle("all_held_idle");
    endtask

    task automatic test_rr();
        logic [NREQ-1:0] pat;
        rand_ops();
        bus.req = 4'b0100;
        expect_frame(model_pick(bus.req), "rr_solo2");
        bus.req = 4'b0101;
        expect_frame(model_pick(bus.req), "rr_0101_first");
        expect_frame(model_pick(bus.req), "rr_0101_second");
        for (int f = 0; f < 12; f++) begin
            pat = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            bus.req = pat;
            if ($urandom_range(0, 1) == 1) rand_ops();
            expect_frame(model_pick(pat), "rr_rand");
        end
        bus.req = '0;
        wait_idle("rr_idle");
    endtask

    task automatic test_timeout();
        int cnt;
        int w;
        logic [NREQ-1:0] oh;
        eng_en  = 1'b0;
        bus.req = 4'b0010;
        w = model_pick(bus.req);
        oh = '0;
        oh[w] = 1'b1;
        cnt = 0;
        while (bus.dac_ext_ctrl !== 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        cnt = 0;
        while (bus.dac_ext_ctrl === 1'b1 && cnt < TIMEOUT_CYC + 50) begin
            cnt++;
            @(negedge clk);
        end
        vecs++;
        if (cnt !== TIMEOUT_CYC) begin
            errs++;
            $display("FAIL timeout_len: start high %0d cycles, required %0d", cnt, TIMEOUT_CYC);
        end
        vecs++;
        if (bus.done !== oh || bus.timeout_err !== 1'b1) begin
            errs++;
            $display("FAIL timeout_flags: done=%b to=%b, required %b 1",
                     bus.done, bus.timeout_err, oh);
        end
        rr_last = w;
        bus.req = '0;
        @(negedge clk);
        vecs++;
        if (bus.done !== '0 || bus.timeout_err !== 1'b0) begin
            errs++;
            $display("FAIL timeout_pulse: done=%b to=%b, required 0 0",
                     bus.done, bus.timeout_err);
        end
        eng_en  = 1'b1;
        bus.req = 4'b1000;
        expect_frame(model_pick(bus.req), "timeout_recover");
        bus.req = '0;
        wait_idle("timeout_idle");
    endtask

    task automatic test_reset_mid();
        int cnt;
        rand_ops();
        bus.req = 4'b0010;
        cnt = 0;
        while (!(bus.dac_sync === 1'b0 && bus.dac_ext_ctrl === 1'b1) && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vecs++;
        if (bus.gnt !== '0 || bus.done !== '0 || bus.busy !== 1'b0
            || bus.dac_ext_ctrl !== 1'b0 || bus.dac_data !== '0) begin
            errs++;
            $display("FAIL reset_mid: gnt=%b done=%b busy=%b ext=%b data=%h, required all 0",
                     bus.gnt, bus.done, bus.busy, bus.dac_ext_ctrl, bus.dac_data);
        end
        repeat (3) @(negedge clk);
        vecs++;
        if (eng_words.size() !== 0) begin
            errs++;
            $display("FAIL reset_mid_abort: %0d words shifted, required 0", eng_words.size());
        end
        rst = 1'b1;
        rr_last = NREQ - 1;
        bus.req = 4'b1111;
        expect_frame(model_pick(bus.req), "reset_mid_first");
        bus.req = '0;
        wait_idle("reset_mid_idle");
    endtask

    task automatic test_data_change();
        int cnt;
        logic [15:0] held;
        rand_ops();
        held = bus.req_data[15:0];
        bus.req = 4'b0001;
        cnt = 0;
        while (bus.gnt === '0 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        bus.req_data[15:0] = ~held;
        bus.req_comm[3:0]  = ~bus.req_comm[3:0];
        expect_frame(model_pick(bus.req), "data_change");
        vecs++;
        if (bus.dac_data !== held) begin
            errs++;
            $display("FAIL data_change_hold: dac_data=%h, required %h", bus.dac_data, held);
        end
        bus.req = '0;
        wait_idle("data_change_idle");
    endtask

    initial begin
        vecs    = 0;
        errs    = 0;
        eng_en  = 1'b1;
        rr_last = NREQ - 1;
        rst     = 1'b0;
        bus.req = '0;
        bus.req_comm = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_all_held();
        test_rr();
        test_timeout();
        test_reset_mid();
        test_data_change();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
